isa_encoder: RTL and testbench

Host-side instruction builder for the CGRA vector/scalar core. It accepts one abstract command per valid/ready handshake and encodes it into the 32-bit instruction format consumed by the core's instruction decoder. It writes each encoded word sequentially into instruction memory. It also expands the load-immediate pseudo-op into two words and seals each program with a terminating `wfi`.

---
 rtl/isa_encoder_if.sv | 32 +++
 rtl/isa_encoder.sv | 201 ++++++++++++++++++++
 tb/tb_isa_encoder.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/isa_encoder_if.sv
// Command handshake and instruction-memory write bus shared by the host and isa_encoder.
interface isa_encoder_if #(
   parameter int unsigned DWIDTH_INST = 32,
   parameter int unsigned IMEM_AW     = 10
);
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [3:0]             cmd_op;
   logic [4:0]             cmd_rd;
   logic [4:0]             cmd_rs1;
   logic [4:0]             cmd_rs2;
   logic [31:0]            cmd_imm;
   logic                   imem_wen;
   logic [IMEM_AW-1:0]     imem_addr;
   logic [DWIDTH_INST-1:0] imem_wdata;
   logic [IMEM_AW:0]       prog_len;
   logic                   prog_done;
   logic                   err_illegal;
   logic                   err_overflow;

   modport master (
      output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
      input  cmd_ready, imem_wen, imem_addr, imem_wdata, prog_len,
             prog_done, err_illegal, err_overflow
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
      output cmd_ready, imem_wen, imem_addr, imem_wdata, prog_len,
             prog_done, err_illegal, err_overflow
   );
endinterface

// File: rtl/isa_encoder.sv
// Encodes host commands into 32-bit core instructions and streams them into instruction memory.
// Define ISA_ENCODER_LI_EN to enable the two-word load-immediate (LI) pseudo-op.
module isa_encoder #(
   parameter int unsigned DWIDTH_INST = 32,
   parameter int unsigned IMEM_AW     = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   isa_encoder_if.slave bus
);
   localparam int unsigned LW = IMEM_AW + 1;
   localparam int unsigned CW = IMEM_AW + 2;
   localparam logic [CW-1:0] LAST_SLOT = CW'((64'd1 << IMEM_AW) - 64'd1);

   localparam logic [3:0] OP_VMACC    = 4'd0;
   localparam logic [3:0] OP_VLE32    = 4'd1;
   localparam logic [3:0] OP_VSE32    = 4'd2;
   localparam logic [3:0] OP_VMV_VI   = 4'd3;
   localparam logic [3:0] OP_VSETIVLI = 4'd4;
   localparam logic [3:0] OP_VSTREAM  = 4'd5;
   localparam logic [3:0] OP_BNE      = 4'd6;
   localparam logic [3:0] OP_ADDI     = 4'd7;
   localparam logic [3:0] OP_LUI      = 4'd8;
   localparam logic [3:0] OP_ADD      = 4'd9;
   localparam logic [3:0] OP_CSR_CYC  = 4'd10;
   localparam logic [3:0] OP_LI       = 4'd11;
   localparam logic [3:0] OP_END      = 4'd12;
   localparam logic [31:0] WFI_WORD   = 32'h1050_0073;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEALED = 2'd1
`ifdef ISA_ENCODER_LI_EN
      , ST_LI_LO = 2'd2
`endif
   } state_e;

   state_e                 state_q, state_d;
   logic                   ready_q, ready_d;
   logic                   wen_q, wen_d;
   logic [IMEM_AW-1:0]     addr_q, addr_d;
   logic [DWIDTH_INST-1:0] wdata_q, wdata_d;
   logic [LW-1:0]          len_q, len_d;
   logic                   done_q, done_d;
   logic                   illegal_q, illegal_d;
   logic                   ovf_q, ovf_d;
`ifdef ISA_ENCODER_LI_EN
   logic [4:0]             li_rd_q, li_rd_d;
   logic [11:0]            li_imm_q, li_imm_d;
   logic                   is_li_c;
`endif
   logic                   accept_c, legal_c, is_end_c, fits_c;
   logic [1:0]             words_c;

   // Single-word encoding of a command; for LI this is the LUI half with the ADDI sign carry folded in.
   function automatic logic [31:0] encode(input logic [3:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [31:0] imm);
      logic [31:0] w;
      w = '0;
      case (op)
         OP_VMACC:    w = {6'b101101, 1'b1, rs2, rs1, 3'b000, rd, 7'h57};
         OP_VLE32:    w = {6'b000000, 1'b1, 5'd0, rs1, 3'b110, rd, 7'h07};
         OP_VSE32:    w = {6'b000000, 1'b1, 5'd0, rs1, 3'b110, rd, 7'h27};
         OP_VMV_VI:   w = {6'b010111, 1'b1, 5'd0, imm[4:0], 3'b101, rd, 7'h57};
         OP_VSETIVLI: w = {2'b11, imm[14:3], imm[2:0], 3'b111, rd, 7'h57};
         OP_VSTREAM:  w = {20'd0, rd, 7'h7F};
         OP_BNE:      w = {imm[11], imm[9:4], rs2, rs1, 3'b001, imm[3:0], imm[10], 7'h63};
         OP_ADDI:     w = {imm[11:0], rs1, 3'b000, rd, 7'h13};
         OP_LUI:      w = {imm[31:12], rd, 7'h37};
         OP_ADD:      w = {7'd0, rs2, rs1, 3'b000, rd, 7'h33};
         OP_CSR_CYC:  w = {12'hC00, 5'd0, 3'b000, rd, 7'h03};
`ifdef ISA_ENCODER_LI_EN
         OP_LI:       w = {imm[31:12] + 20'(imm[11]), rd, 7'h37};
`endif
         OP_END:      w = WFI_WORD;
         default:     w = '0;
      endcase
      return w;
   endfunction

   assign accept_c = bus.cmd_valid & ready_q;
   assign is_end_c = (bus.cmd_op == OP_END);
`ifdef ISA_ENCODER_LI_EN
   assign is_li_c  = (bus.cmd_op == OP_LI);
   assign legal_c  = (bus.cmd_op <= OP_END);
   assign words_c  = is_li_c ? 2'd2 : 2'd1;
`else
   assign legal_c  = (bus.cmd_op <= OP_END) && (bus.cmd_op != OP_LI);
   assign words_c  = 2'd1;
`endif
   // The top slot stays reserved so a program can always be sealed.
   assign fits_c   = (CW'(len_q) + CW'(words_c)) <= LAST_SLOT;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state_q   <= ST_IDLE;
         ready_q   <= 1'b0;
         wen_q     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         len_q     <= '0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         ovf_q     <= 1'b0;
`ifdef ISA_ENCODER_LI_EN
         li_rd_q   <= '0;
         li_imm_q  <= '0;
`endif
      end else begin
         state_q   <= state_d;
         ready_q   <= ready_d;
         wen_q     <= wen_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         len_q     <= len_d;
         done_q    <= done_d;
         illegal_q <= illegal_d;
         ovf_q     <= ovf_d;
`ifdef ISA_ENCODER_LI_EN
         li_rd_q   <= li_rd_d;
         li_imm_q  <= li_imm_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_c && legal_c) begin
               if (is_end_c) state_d = ST_SEALED;
`ifdef ISA_ENCODER_LI_EN
               else if (is_li_c && fits_c) state_d = ST_LI_LO;
`endif
            end
         end
`ifdef ISA_ENCODER_LI_EN
         ST_LI_LO: state_d = ST_IDLE;
`endif
         default:  state_d = state_q;
      endcase
   end

   // Next values of the registered outputs; ready mirrors whether the next state takes commands.
   always_comb begin
      ready_d   = (state_d == ST_IDLE);
      wen_d     = 1'b0;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      len_d     = len_q;
      done_d    = done_q;
      illegal_d = 1'b0;
      ovf_d     = ovf_q;
`ifdef ISA_ENCODER_LI_EN
      li_rd_d   = li_rd_q;
      li_imm_d  = li_imm_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               if (!legal_c) begin
                  illegal_d = 1'b1;
               end else if (is_end_c || fits_c) begin
                  wen_d   = 1'b1;
                  addr_d  = len_q[IMEM_AW-1:0];
                  wdata_d = DWIDTH_INST'(encode(bus.cmd_op, bus.cmd_rd, bus.cmd_rs1,
                                                bus.cmd_rs2, bus.cmd_imm));
                  len_d   = len_q + LW'(1);
                  done_d  = done_q | is_end_c;
               end else begin
                  ovf_d = 1'b1;
               end
`ifdef ISA_ENCODER_LI_EN
               li_rd_d  = bus.cmd_rd;
               li_imm_d = bus.cmd_imm[11:0];
`endif
            end
         end
`ifdef ISA_ENCODER_LI_EN
         ST_LI_LO: begin
            wen_d   = 1'b1;
            addr_d  = len_q[IMEM_AW-1:0];
            wdata_d = DWIDTH_INST'({li_imm_q, li_rd_q, 3'b000, li_rd_q, 7'h13});
            len_d   = len_q + LW'(1);
         end
`endif
         default: ;
      endcase
   end

   assign bus.cmd_ready    = ready_q;
   assign bus.imem_wen     = wen_q;
   assign bus.imem_addr    = addr_q;
   assign bus.imem_wdata   = wdata_q;
   assign bus.prog_len     = len_q;
   assign bus.prog_done    = done_q;
   assign bus.err_illegal  = illegal_q;
   assign bus.err_overflow = ovf_q;
endmodule

// File: tb/tb_isa_encoder.sv
// Self-checking bench for isa_encoder: directed test-plan cases plus random traffic against a word-queue model.
module tb_isa_encoder;
   localparam int unsigned AW    = 2;
   localparam int unsigned DEPTH = 1 << AW;
`ifdef ISA_ENCODER_LI_EN
   localparam bit LI_EN = 1'b1;
`else
   localparam bit LI_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic clear;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   isa_encoder_if #(.DWIDTH_INST(32), .IMEM_AW(AW)) bus ();

   isa_encoder #(.DWIDTH_INST(32), .IMEM_AW(AW)) dut (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .bus   (bus)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Instruction words built from field values by shift-and-add.
   function automatic logic [31:0] ref_word(input int op, input logic [31:0] rd,
                                            input logic [31:0] rs1, input logic [31:0] rs2,
                                            input logic [31:0] imm);
      logic [31:0] b;
      b = imm & 32'hFFF;
      case (op)
         0:  return (32'd45 << 26) + (32'd1 << 25) + (rs2 << 20) + (rs1 << 15) + (rd << 7) + 32'h57;
         1:  return (32'd1 << 25) + (rs1 << 15) + (32'd6 << 12) + (rd << 7) + 32'h07;
         2:  return (32'd1 << 25) + (rs1 << 15) + (32'd6 << 12) + (rd << 7) + 32'h27;
         3:  return (32'd23 << 26) + (32'd1 << 25) + ((imm & 32'd31) << 15) + (32'd5 << 12)
                    + (rd << 7) + 32'h57;
         4:  return (32'd3 << 30) + (((imm >> 3) & 32'hFFF) << 18) + ((imm & 32'd7) << 15)
                    + (32'd7 << 12) + (rd << 7) + 32'h57;
         5:  return (rd << 7) + 32'h7F;
         6:  return ((b >> 11) << 31) + (((b >> 4) & 32'd63) << 25) + (rs2 << 20) + (rs1 << 15)
                    + (32'd1 << 12) + ((b & 32'd15) << 8) + (((b >> 10) & 32'd1) << 7) + 32'h63;
         7:  return (b << 20) + (rs1 << 15) + (rd << 7) + 32'h13;
         8:  return (imm & 32'hFFFF_F000) + (rd << 7) + 32'h37;
         9:  return (rs2 << 20) + (rs1 << 15) + (rd << 7) + 32'h33;
         10: return (32'hC00 << 20) + (rd << 7) + 32'h03;
         11: return ((((imm >> 12) + ((imm >> 11) & 32'd1)) & 32'hF_FFFF) << 12) + (rd << 7) + 32'h37;
         12: return 32'h1050_0073;
         default: return 32'h0;
      endcase
   endfunction

   // Reference model: pending words drain one per cycle; commands are taken only when nothing is pending.
   logic        m_live = 1'b0;
   logic        m_ready, m_wen, m_done, m_ill, m_ovf, m_sealed;
   logic [31:0] m_addr, m_wdata, m_len;
   logic [31:0] pend[$];

   task automatic m_emit(input logic [31:0] w);
      m_wen   = 1'b1;
      m_addr  = m_len;
      m_wdata = w;
      m_len   = m_len + 1;
   endtask

   always @(posedge clk) begin
      int op, n;
      logic [31:0] rd, rs1, rs2, imm;
      if (rst || clear) begin
         m_live = 1'b1; m_ready = 1'b0; m_wen = 1'b0; m_done = 1'b0; m_ill = 1'b0;
         m_ovf = 1'b0; m_sealed = 1'b0; m_addr = 0; m_wdata = 0; m_len = 0;
         pend.delete();
      end else if (m_live) begin
         op  = int'(bus.cmd_op);
         rd  = 32'(bus.cmd_rd);
         rs1 = 32'(bus.cmd_rs1);
         rs2 = 32'(bus.cmd_rs2);
         imm = bus.cmd_imm;
         m_wen = 1'b0;
         m_ill = 1'b0;
         if (pend.size() > 0) begin
            m_emit(pend.pop_front());
         end else if (bus.cmd_valid && m_ready) begin
            n = (op == 11) ? 2 : 1;
            if (op > 12 || (op == 11 && !LI_EN)) begin
               m_ill = 1'b1;
            end else if (op == 12) begin
               m_emit(ref_word(12, rd, rs1, rs2, imm));
               m_done   = 1'b1;
               m_sealed = 1'b1;
            end else if (m_len + 32'(n) > 32'(DEPTH - 1)) begin
               m_ovf = 1'b1;
            end else begin
               m_emit(ref_word(op, rd, rs1, rs2, imm));
               if (n == 2) pend.push_back(ref_word(7, rd, rd, 0, imm));
            end
         end
         m_ready = !m_sealed && (pend.size() == 0);
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         chk("cmd_ready", 64'(bus.cmd_ready), 64'(m_ready));
         chk("imem_wen", 64'(bus.imem_wen), 64'(m_wen));
         if (m_wen) begin
            chk("imem_addr", 64'(bus.imem_addr), 64'(m_addr));
            chk("imem_wdata", 64'(bus.imem_wdata), 64'(m_wdata));
         end
         chk("prog_len", 64'(bus.prog_len), 64'(m_len));
         chk("prog_done", 64'(bus.prog_done), 64'(m_done));
         chk("err_illegal", 64'(bus.err_illegal), 64'(m_ill));
         chk("err_overflow", 64'(bus.err_overflow), 64'(m_ovf));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
      bit acc;
      int cyc;
      bus.cmd_op = op; bus.cmd_rd = rd; bus.cmd_rs1 = rs1; bus.cmd_rs2 = rs2; bus.cmd_imm = imm;
      bus.cmd_valid = 1'b1;
      acc = 1'b0;
      cyc = 0;
      while (!acc && cyc < 20) begin
         acc = bus.cmd_ready;
         tick();
         cyc++;
      end
      bus.cmd_valid = 1'b0;
      if (!acc) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout: op=%0d not accepted within 20 cycles", op);
      end
   endtask

   task automatic exp_write(input string name, input logic [31:0] addr, input logic [31:0] data);
      chk({name, "_wen"}, 64'(bus.imem_wen), 64'd1);
      chk({name, "_addr"}, 64'(bus.imem_addr), 64'(addr));
      chk({name, "_wdata"}, 64'(bus.imem_wdata), 64'(data));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      rst = 1'b1; clear = 1'b0;
      bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_rd = '0;
      bus.cmd_rs1 = '0; bus.cmd_rs2 = '0; bus.cmd_imm = '0;
      tick();
      chk("rst_ready", 64'(bus.cmd_ready), 64'd0);
      chk("rst_len", 64'(bus.prog_len), 64'd0);
      chk("rst_wdata", 64'(bus.imem_wdata), 64'd0);
      rst = 1'b0;
      tick();
      chk("ready_after_rst", 64'(bus.cmd_ready), 64'd1);

      send(4'd7, 5'd3, 5'd0, 5'd0, 32'h005);
      exp_write("addi", 0, 32'h0050_0193);
      chk("addi_len", 64'(bus.prog_len), 64'd1);
      send(4'd4, 5'd1, 5'd0, 5'd0, (32'h010 << 3) | 32'd3);
      exp_write("vsetivli", 1, 32'hC041_F0D7);
      send(4'd6, 5'd0, 5'd1, 5'd2, 32'hABC);
      exp_write("bne", 2, 32'hD620_9C63);
      chk("full_len", 64'(bus.prog_len), 64'd3);
      send(4'd7, 5'd4, 5'd4, 5'd0, 32'h001);
      chk("ovf_wen", 64'(bus.imem_wen), 64'd0);
      chk("ovf_flag", 64'(bus.err_overflow), 64'd1);
      send(4'd12, 5'd0, 5'd0, 5'd0, 32'h0);
      exp_write("end", 3, 32'h1050_0073);
      chk("end_done", 64'(bus.prog_done), 64'd1);
      chk("end_ready", 64'(bus.cmd_ready), 64'd0);
      tick();
      chk("sealed_ready", 64'(bus.cmd_ready), 64'd0);

      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_len", 64'(bus.prog_len), 64'd0);
      chk("clr_done", 64'(bus.prog_done), 64'd0);
      chk("clr_ovf", 64'(bus.err_overflow), 64'd0);
      tick();
      chk("clr_ready", 64'(bus.cmd_ready), 64'd1);

      send(4'd11, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
`ifdef ISA_ENCODER_LI_EN
      exp_write("li_lui", 0, 32'h1234_62B7);
      chk("li_ready_lo", 64'(bus.cmd_ready), 64'd0);
      tick();
      exp_write("li_addi", 1, 32'hFFF2_8293);
      chk("li_ready_back", 64'(bus.cmd_ready), 64'd1);
`else
      chk("li_off_wen", 64'(bus.imem_wen), 64'd0);
      chk("li_off_illegal", 64'(bus.err_illegal), 64'd1);
`endif

      send(4'd14, 5'd1, 5'd1, 5'd1, 32'h0);
      chk("op14_illegal", 64'(bus.err_illegal), 64'd1);
      chk("op14_wen", 64'(bus.imem_wen), 64'd0);
      tick();
      chk("op14_pulse_end", 64'(bus.err_illegal), 64'd0);

      bus.cmd_op = 4'd7; bus.cmd_rd = 5'd2; bus.cmd_imm = 32'h7;
      bus.cmd_valid = 1'b1; clear = 1'b1;
      tick();
      bus.cmd_valid = 1'b0; clear = 1'b0;
      chk("clr_prio_wen", 64'(bus.imem_wen), 64'd0);
      chk("clr_prio_len", 64'(bus.prog_len), 64'd0);

`ifdef ISA_ENCODER_LI_EN
      send(4'd11, 5'd6, 5'd0, 5'd0, 32'h0000_0800);
      exp_write("li2_lui", 0, 32'h0000_1337);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("li_abort_wen", 64'(bus.imem_wen), 64'd0);
      chk("li_abort_len", 64'(bus.prog_len), 64'd0);
`endif
      send(4'd7, 5'd1, 5'd0, 5'd0, 32'h001);
      exp_write("post_clear", 0, 32'h0010_0093);

      for (int i = 0; i < 4000; i++) begin
         r = int'($urandom_range(99));
         rst   = (r < 1);
         clear = (r >= 1 && r < 5);
         bus.cmd_valid = ($urandom_range(9) < 7);
         bus.cmd_op    = ($urandom_range(9) < 8) ? 4'($urandom_range(12)) : 4'($urandom_range(15));
         bus.cmd_rd    = 5'($urandom);
         bus.cmd_rs1   = 5'($urandom);
         bus.cmd_rs2   = 5'($urandom);
         bus.cmd_imm   = ($urandom_range(3) == 0) ? 32'($urandom_range(4095)) : $urandom;
         tick();
      end
      rst = 1'b0; clear = 1'b0; bus.cmd_valid = 1'b0;
      tick();
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
